// File: rtl/dsp_adder24.sv
// Dual-lane unsigned adder with a two-stage pipeline (operand register, sum register).
// Define DSP_ADDER24_CE_EN to add a clock-enable input CE; RST overrides CE.
module dsp_adder24 #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef DSP_ADDER24_CE_EN
    input  logic             CE,
`endif
    input  logic [WIDTH-1:0] AIN1,
    input  logic [WIDTH-1:0] AIN2,
    input  logic [WIDTH-1:0] BIN1,
    input  logic [WIDTH-1:0] BIN2,
    output logic [WIDTH:0]   OUT1,
    output logic [WIDTH:0]   OUT2
);

    logic             en;
    logic [WIDTH-1:0] a1_q, a2_q, b1_q, b2_q;
    logic [WIDTH:0]   sum1_q, sum2_q;
    logic [WIDTH:0]   sum1_d, sum2_d;

`ifdef DSP_ADDER24_CE_EN
    assign en = CE;
`else
    assign en = 1'b1;
`endif

    // Each lane is widened on its own, so no carry can reach the other lane.
    always_comb begin
        sum1_d = {1'b0, a1_q} + {1'b0, a2_q};
        sum2_d = {1'b0, b1_q} + {1'b0, b2_q};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a1_q   <= '0;
            a2_q   <= '0;
            b1_q   <= '0;
            b2_q   <= '0;
            sum1_q <= '0;
            sum2_q <= '0;
        end else if (en) begin
            a1_q   <= AIN1;
            a2_q   <= AIN2;
            b1_q   <= BIN1;
            b2_q   <= BIN2;
            sum1_q <= sum1_d;
            sum2_q <= sum2_d;
        end
    end

    assign OUT1 = sum1_q;
    assign OUT2 = sum2_q;

endmodule

// File: tb/tb_dsp_adder24.sv
// Directed-vector bench for dsp_adder24; define DSP_ADDER24_CE_EN to also cover CE.
module tb_dsp_adder24;

    logic        CLK = 1'b0;
    logic        RST;
`ifdef DSP_ADDER24_CE_EN
    logic        CE;
`endif
    logic [23:0] AIN1, AIN2, BIN1, BIN2;
    logic [24:0] OUT1, OUT2;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    dsp_adder24 #(.WIDTH(24)) dut (
        .CLK (CLK),
        .RST (RST),
`ifdef DSP_ADDER24_CE_EN
        .CE  (CE),
`endif
        .AIN1(AIN1),
        .AIN2(AIN2),
        .BIN1(BIN1),
        .BIN2(BIN2),
        .OUT1(OUT1),
        .OUT2(OUT2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 25'h%07h, expected 25'h%07h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [23:0] a1, input logic [23:0] a2,
                         input logic [23:0] b1, input logic [23:0] b2);
        AIN1 = a1;
        AIN2 = a2;
        BIN1 = b1;
        BIN2 = b2;
    endtask

    initial begin
        RST = 1'b1;
`ifdef DSP_ADDER24_CE_EN
        CE  = 1'b1;
`endif
        drive(24'h123456, 24'hABCDEF, 24'h777777, 24'h0F0F0F);

        // Reset held for two edges with arbitrary operands present
        step();
        check("rst1_out1", OUT1, 25'h0);
        check("rst1_out2", OUT2, 25'h0);
        step();
        check("rst2_out1", OUT1, 25'h0);
        check("rst2_out2", OUT2, 25'h0);
        RST = 1'b0;
        drive(24'd100, 24'd23, 24'd1, 24'd2);
        step();
        check("post_rst_out1", OUT1, 25'h0);
        check("post_rst_out2", OUT2, 25'h0);
        // Nominal vector goes in while the first post-reset operands emerge
        drive(24'd8299999, 24'd1010010, 24'd8288888, 24'd512);
        step();
        check("first_out1", OUT1, 25'd123);
        check("first_out2", OUT2, 25'd3);
        step();
        check("nom_out1", OUT1, 25'h08E0F39);
        check("nom_out2", OUT2, 25'h07E7C78);

        // Crossing 2^23
        drive(24'd2020, 24'd8388607, 24'd2020, 24'd8388607);
        step();
        step();
        check("x23_out1", OUT1, 25'h08007E3);
        check("x23_out2", OUT2, 25'h08007E3);

        // Carry-out on lane A, lane B idle
        drive(24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0);
        step();
        step();
        check("cy_out1", OUT1, 25'h1FFFFFE);
        check("cy_out2", OUT2, 25'h0);
        // Mirror: carry on lane B only
        drive(24'h0, 24'h0, 24'hFFFFFF, 24'h000001);
        step();
        step();
        check("cyb_out1", OUT1, 25'h0);
        check("cyb_out2", OUT2, 25'h1000000);

        // Back-to-back operand sets
        drive(24'd10, 24'd10, 24'd10, 24'd10);
        step();
        drive(24'd1115, 24'd1115, 24'd1115, 24'd1115);
        step();
        check("b2b0_out1", OUT1, 25'h14);
        check("b2b0_out2", OUT2, 25'h14);
        drive(24'd0, 24'd0, 24'd0, 24'd0);
        step();
        check("b2b1_out1", OUT1, 25'h8B6);
        check("b2b1_out2", OUT2, 25'h8B6);

        // Mid-stream reset discards the set captured just before it
        drive(24'd100, 24'd200, 24'd300, 24'd400);
        step();
        RST = 1'b1;
        drive(24'd1000, 24'd2000, 24'd3000, 24'd4000);
        step();
        check("mid_rst_out1", OUT1, 25'h0);
        check("mid_rst_out2", OUT2, 25'h0);
        RST = 1'b0;
        drive(24'd5, 24'd6, 24'd7, 24'd8);
        step();
        check("mid_flush_out1", OUT1, 25'h0);
        check("mid_flush_out2", OUT2, 25'h0);
        step();
        check("mid_resume_out1", OUT1, 25'd11);
        check("mid_resume_out2", OUT2, 25'd15);

`ifdef DSP_ADDER24_CE_EN
        // Clock enable: hold for three cycles, then resume
        drive(24'd1, 24'd2, 24'd10, 24'd20);
        step();
        drive(24'd3, 24'd4, 24'd30, 24'd40);
        step();
        check("ce_pre_out1", OUT1, 25'd3);
        check("ce_pre_out2", OUT2, 25'd30);
        CE = 1'b0;
        drive(24'd7, 24'd8, 24'd70, 24'd80);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ce_hold_out1", OUT1, 25'd3);
            check("ce_hold_out2", OUT2, 25'd30);
        end
        CE = 1'b1;
        step();
        check("ce_res0_out1", OUT1, 25'd7);
        check("ce_res0_out2", OUT2, 25'd70);
        step();
        check("ce_res1_out1", OUT1, 25'd15);
        check("ce_res1_out2", OUT2, 25'd150);
        // Reset wins over a deasserted enable
        CE  = 1'b0;
        RST = 1'b1;
        step();
        check("ce_rst_out1", OUT1, 25'h0);
        check("ce_rst_out2", OUT2, 25'h0);
        RST = 1'b0;
        CE  = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dsp_adder24.md
Name: dsp_adder24

Overview:
Dual-lane 24-bit unsigned adder, modelled on the DSP48E SIMD "TWO24" add mode.
- Two independent additions per clock: AIN1+AIN2 into OUT1, and BIN1+BIN2 into OUT2.
- Each result is 25 bits, so the carry-out is kept.
- Sits in the DSP datapath as a pipelined add stage with a fixed latency of 2 cycles.

Parameters:
- WIDTH, 24, operand width per lane. Each result is WIDTH+1 bits. Must be 24 or less for a DSP48E SIMD mapping.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high; clears every register on the next rising CLK.
- AIN1  input  24  lane A operand 1, unsigned.
- AIN2  input  24  lane A operand 2, unsigned.
- BIN1  input  24  lane B operand 1, unsigned.
- BIN2  input  24  lane B operand 2, unsigned.
- OUT1  output  25  lane A sum; bit 24 is the carry-out.
- OUT2  output  25  lane B sum; bit 24 is the carry-out.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high (RST). RST is sampled only on a rising CLK edge.
- Reset:
  - While RST=1 at an edge, all input and output pipeline registers load 0.
  - OUT1=0 and OUT2=0 from the first edge with RST=1 until valid data has passed through.
- Pipeline, two register stages:
  - Stage 1: edge k registers AIN1, AIN2, BIN1, BIN2.
  - Stage 2: edge k+1 registers the sums.
  - Operands present at edge k appear on OUT1/OUT2 just after edge k+1 (latency 2).
  - One new operand set is accepted per cycle. No handshake and no stalls.
- Arithmetic:
  - OUT1 = zero-extended AIN1 + zero-extended AIN2, full 25-bit result, with no wrap or saturation.
  - OUT2 is computed the same way from BIN1 and BIN2.
  - The lanes are fully independent: a carry out of lane A never enters lane B, and vice versa.
  - Maximum result per lane: 24'hFFFFFF + 24'hFFFFFF = 25'h1FFFFFE.
- Unknown/X inputs after reset: the output reflects whatever was registered. The design takes no special handling for this.
- Reset mid-stream:
  - Data in flight is discarded.
  - Outputs are 0 on the edge after RST is asserted.
  - After RST deasserts, the first operands captured appear 2 edges later.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: DSP_ADDER24_CE_EN.
- When defined:
  - Adds input port CE (1 bit, active-high), placed after RST.
  - Both pipeline stages update only when CE=1; with CE=0 all registers hold their value.
  - RST takes priority over CE: reset clears the registers even when CE=0.
- When not defined: there is no CE port and the registers update on every edge.

Test Plan:
- Reset: RST=1 for 2 edges with arbitrary inputs -> OUT1=0 and OUT2=0 while in reset and on the first edge after RST falls.
- Nominal, applied at edge k:
  - Inputs: AIN1=8299999, AIN2=1010010, BIN1=8288888, BIN2=512.
  - Required after edge k+1: OUT1=25'h08E0F39 (9310009) and OUT2=25'h07E7C78 (8289400).
- Crossing 2^23: AIN1=BIN1=2020, AIN2=BIN2=8388607 -> OUT1=OUT2=25'h08007E3 two edges later.
- Carry-out and lane isolation:
  - Inputs: AIN1=AIN2=24'hFFFFFF, BIN1=BIN2=0.
  - Required: OUT1=25'h1FFFFFE and OUT2=0. OUT2 stays 0, proving no carry crosses lanes.
- Back-to-back stream:
  - Inputs change every cycle: (10,10) then (1115,1115), on both lanes.
  - Required: outputs 25'h14 then 25'h8B6 on consecutive cycles, each with latency 2.
- Mid-stream reset: assert RST for one edge while valid data is in flight -> in-flight results are never output; OUT is 0 for that cycle.
- CE (DSP_ADDER24_CE_EN defined): drop CE for 3 cycles -> outputs hold their value; they resume correctly once CE returns to 1.
